regread_sched: RTL and testbench

- Sequencer for the decode-stage register-file read port in the SEQ Y86-64 core. The register file exposes a single asynchronous read port.
- Per accepted instruction, the block selects srcA/srcB from icode, rA and rB, and serialises up to two reads through that port.
- Same-cycle writeback is forwarded into the captured operand.
- valA/valB are presented to execute through a valid/ready handshake.

---
 rtl/regread_sched.sv | 181 ++++++++++++++++++
 tb/tb_regread_sched.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regread_sched.sv
// regread_sched
//   Decode-stage register-file read sequencer for the SEQ Y86-64 core.
//   For each accepted instruction it derives srcA/srcB from icode, rA and rB,
//   then serialises up to two reads through the single asynchronous
//   register-file read port. A writeback in the same cycle as a read (or while
//   the result waits in DONE) is forwarded into the captured operand.
//   valA/valB are handed to execute with a valid/ready handshake.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  decode request handshake (ready only in IDLE)
//   icode, rA, rB        instruction fields used for source selection
//   rf_raddr, rf_ren     register-file read address / read strobe
//   rf_rdata             combinational read data for rf_raddr
//   wb_en, wb_dst,       writeback strobe, destination and value, same
//   wb_data              cycle as the register-file write
//   out_valid/out_ready  operand handshake towards execute
//   valA, valB           captured operands
module regread_sched #(
  parameter int RSP_IDX  = 14,
  parameter int NONE_IDX = 15,
  parameter int W        = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [3:0]   icode,
  input  logic [3:0]   rA,
  input  logic [3:0]   rB,
  output logic [3:0]   rf_raddr,
  output logic         rf_ren,
  input  logic [W-1:0] rf_rdata,
  input  logic         wb_en,
  input  logic [3:0]   wb_dst,
  input  logic [W-1:0] wb_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] valA,
  output logic [W-1:0] valB
);

  localparam logic [3:0] RSP  = 4'(RSP_IDX);
  localparam logic [3:0] NONE = 4'(NONE_IDX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_A = 2'd1,
    RD_B = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state_reg;
  logic [3:0]     srca_reg;
  logic [3:0]     srcb_reg;
  logic [W-1:0]   vala_reg;
  logic [W-1:0]   valb_reg;
  logic           out_valid_reg;
  logic           rf_ren_reg;
  logic [3:0]     rf_raddr_reg;

  logic [3:0]     srca_next;
  logic [3:0]     srcb_next;
  logic [W-1:0]   fwd_data;
  logic           wb_hits_a;
  logic           wb_hits_b;

  // Source selection from the instruction code.
  always_comb begin
    srca_next = NONE;
    srcb_next = NONE;
    case (icode)
      4'd2, 4'd4, 4'd6, 4'd10: srca_next = rA;
      4'd9, 4'd11:             srca_next = RSP;
      default:                 srca_next = NONE;
    endcase
    case (icode)
      4'd4, 4'd5, 4'd6:               srcb_next = rB;
      4'd8, 4'd9, 4'd10, 4'd11:       srcb_next = RSP;
      default:                        srcb_next = NONE;
    endcase
  end

  // The read address register always holds the register being read in
  // RD_A/RD_B, so forwarding compares against it. NONE is never a real
  // destination, so a writeback to it is ignored.
  assign fwd_data  = (wb_en && (wb_dst != NONE) && (wb_dst == rf_raddr_reg))
                     ? wb_data : rf_rdata;
  assign wb_hits_a = wb_en && (wb_dst != NONE) && (wb_dst == srca_reg);
  assign wb_hits_b = wb_en && (wb_dst != NONE) && (wb_dst == srcb_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      srca_reg      <= NONE;
      srcb_reg      <= NONE;
      vala_reg      <= '0;
      valb_reg      <= '0;
      out_valid_reg <= 1'b0;
      rf_ren_reg    <= 1'b0;
      rf_raddr_reg  <= NONE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            srca_reg <= srca_next;
            srcb_reg <= srcb_next;
            vala_reg <= '0;
            valb_reg <= '0;
            if (srca_next != NONE) begin
              state_reg    <= RD_A;
              rf_ren_reg   <= 1'b1;
              rf_raddr_reg <= srca_next;
            end else if (srcb_next != NONE) begin
              state_reg    <= RD_B;
              rf_ren_reg   <= 1'b1;
              rf_raddr_reg <= srcb_next;
            end else begin
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
            end
          end
        end

        RD_A: begin
          vala_reg <= fwd_data;
          if ((srcb_reg != NONE) && (srcb_reg != srca_reg)) begin
            state_reg    <= RD_B;
            rf_raddr_reg <= srcb_reg;
          end else begin
            // Same register on both sides (e.g. popq): reuse this read.
            if (srcb_reg == srca_reg) begin
              valb_reg <= fwd_data;
            end
            state_reg     <= DONE;
            rf_ren_reg    <= 1'b0;
            rf_raddr_reg  <= NONE;
            out_valid_reg <= 1'b1;
          end
        end

        RD_B: begin
          valb_reg      <= fwd_data;
          state_reg     <= DONE;
          rf_ren_reg    <= 1'b0;
          rf_raddr_reg  <= NONE;
          out_valid_reg <= 1'b1;
        end

        DONE: begin
          // Keep waiting operands fresh against later writebacks.
          if (wb_hits_a) begin
            vala_reg <= wb_data;
          end
          if (wb_hits_b) begin
            valb_reg <= wb_data;
          end
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
          end
        end

        default: begin
          state_reg     <= IDLE;
          rf_ren_reg    <= 1'b0;
          rf_raddr_reg  <= NONE;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign rf_ren    = rf_ren_reg;
  assign rf_raddr  = rf_raddr_reg;
  assign out_valid = out_valid_reg;
  assign valA      = vala_reg;
  assign valB      = valb_reg;

endmodule

// File: tb/tb_regread_sched.sv
module tb_regread_sched;

  localparam int W = 64;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   icode;
  logic [3:0]   rA;
  logic [3:0]   rB;
  logic [3:0]   rf_raddr;
  logic         rf_ren;
  logic [W-1:0] rf_rdata;
  logic         wb_en;
  logic [3:0]   wb_dst;
  logic [W-1:0] wb_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] valA;
  logic [W-1:0] valB;

  // Bench-side register file, written only from the stimulus process.
  logic [W-1:0] regs [16];
  assign rf_rdata = regs[rf_raddr];

  int errors = 0;
  int checks = 0;

  // Results of the most recent request.
  int         lat;
  int         n_rd;
  logic [3:0] rd_addr [4];

  regread_sched #(.RSP_IDX(14), .NONE_IDX(15), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .icode     (icode),
    .rA        (rA),
    .rB        (rB),
    .rf_raddr  (rf_raddr),
    .rf_ren    (rf_ren),
    .rf_rdata  (rf_rdata),
    .wb_en     (wb_en),
    .wb_dst    (wb_dst),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .valA      (valA),
    .valB      (valB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issue one request and step until out_valid, logging read addresses.
  // Optionally applies a writeback during the first cycle after accept.
  task automatic do_req(input logic [3:0] ic, input logic [3:0] ra,
                        input logic [3:0] rb, input logic use_wb,
                        input logic [3:0] wdst, input logic [W-1:0] wdat);
    icode     = ic;
    rA        = ra;
    rB        = rb;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat  = 1;
    n_rd = 0;
    if (use_wb) begin
      wb_en   = 1'b1;
      wb_dst  = wdst;
      wb_data = wdat;
    end
    while (!out_valid && lat < 8) begin
      if (rf_ren) begin
        if (n_rd < 4) rd_addr[n_rd] = rf_raddr;
        n_rd++;
      end
      checks++;
      if (req_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_req_ready: got %b expected 0 (icode %0d)", req_ready, ic);
      end
      @(posedge clk); #1;
      lat++;
      if (wb_en) begin
        regs[wb_dst] = wb_data;
        wb_en = 1'b0;
      end
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL out_valid_timeout: out_valid never rose for icode %0d", ic);
    end
    $display("req icode=%0d rA=%0d rB=%0d lat=%0d reads=%0d valA=%0h valB=%0h",
             ic, ra, rb, lat, n_rd, valA, valB);
  endtask

  task automatic finish_handshake(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_handshake: out_valid=%b req_ready=%b expected 0/1", name, out_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #2;
    checks++;
    if (req_ready !== 1'b1 || out_valid !== 1'b0 || rf_ren !== 1'b0 ||
        rf_raddr !== 4'd15 || valA !== '0 || valB !== '0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b ov=%b ren=%b raddr=%0d valA=%0h valB=%0h expected 1/0/0/15/0/0",
               req_ready, out_valid, rf_ren, rf_raddr, valA, valB);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rdy=%b ov=%b expected 1/0", req_ready, out_valid);
    end
  endtask

  task automatic test_two_reads();
    regs[1] = 64'h11;
    regs[2] = 64'h22;
    out_ready = 1'b1;
    do_req(4'd6, 4'd1, 4'd2, 1'b0, 4'd0, '0);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL opq_latency: got %0d expected 3", lat);
    end
    checks++;
    if (n_rd != 2 || rd_addr[0] !== 4'd1 || rd_addr[1] !== 4'd2) begin
      errors++;
      $display("FAIL opq_read_order: reads=%0d a0=%0d a1=%0d expected 2/1/2", n_rd, rd_addr[0], rd_addr[1]);
    end
    checks++;
    if (valA !== 64'h11 || valB !== 64'h22) begin
      errors++;
      $display("FAIL opq_values: valA=%0h valB=%0h expected 11/22", valA, valB);
    end
    checks++;
    if (rf_ren !== 1'b0 || rf_raddr !== 4'd15) begin
      errors++;
      $display("FAIL done_port_idle: ren=%b raddr=%0d expected 0/15", rf_ren, rf_raddr);
    end
    finish_handshake("opq");
  endtask

  task automatic test_popq_shared_read();
    regs[14] = 64'h1000;
    do_req(4'd11, 4'd7, 4'd15, 1'b0, 4'd0, '0);
    checks++;
    if (lat != 2 || n_rd != 1 || rd_addr[0] !== 4'd14) begin
      errors++;
      $display("FAIL popq_reads: lat=%0d reads=%0d a0=%0d expected 2/1/14", lat, n_rd, rd_addr[0]);
    end
    checks++;
    if (valA !== 64'h1000 || valB !== 64'h1000) begin
      errors++;
      $display("FAIL popq_values: valA=%0h valB=%0h expected 1000/1000", valA, valB);
    end
    finish_handshake("popq");
  endtask

  task automatic test_forward_in_read();
    regs[3]  = 64'h5;
    regs[14] = 64'h2000;
    do_req(4'd10, 4'd3, 4'd15, 1'b1, 4'd3, 64'hAB);
    checks++;
    if (lat != 3 || n_rd != 2 || rd_addr[0] !== 4'd3 || rd_addr[1] !== 4'd14) begin
      errors++;
      $display("FAIL pushq_reads: lat=%0d reads=%0d a0=%0d a1=%0d expected 3/2/3/14",
               lat, n_rd, rd_addr[0], rd_addr[1]);
    end
    checks++;
    if (valA !== 64'hAB || valB !== 64'h2000) begin
      errors++;
      $display("FAIL pushq_forward: valA=%0h valB=%0h expected ab/2000", valA, valB);
    end
    finish_handshake("pushq");
  endtask

  task automatic test_done_freshen();
    regs[4] = 64'h44;
    out_ready = 1'b0;
    do_req(4'd2, 4'd4, 4'd9, 1'b0, 4'd0, '0);
    checks++;
    if (lat != 2 || n_rd != 1 || valA !== 64'h44 || valB !== '0) begin
      errors++;
      $display("FAIL cmov_first: lat=%0d reads=%0d valA=%0h valB=%0h expected 2/1/44/0",
               lat, n_rd, valA, valB);
    end
    wb_en = 1'b1; wb_dst = 4'd4; wb_data = 64'h99;
    @(posedge clk); #1;
    regs[4] = 64'h99;
    wb_en = 1'b0;
    checks++;
    if (valA !== 64'h99 || valB !== '0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL cmov_freshen: valA=%0h valB=%0h ov=%b expected 99/0/1", valA, valB, out_valid);
    end
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || valA !== 64'h99) begin
        errors++;
        $display("FAIL cmov_hold: ov=%b valA=%0h expected 1/99", out_valid, valA);
      end
    end
    finish_handshake("cmov");
  endtask

  task automatic test_no_reads();
    do_req(4'd3, 4'd1, 4'd2, 1'b0, 4'd0, '0);
    checks++;
    if (lat != 1 || n_rd != 0 || rf_ren !== 1'b0 || valA !== '0 || valB !== '0) begin
      errors++;
      $display("FAIL irmovq_noread: lat=%0d reads=%0d ren=%b valA=%0h valB=%0h expected 1/0/0/0/0",
               lat, n_rd, rf_ren, valA, valB);
    end
    finish_handshake("irmovq");
    do_req(4'd13, 4'd1, 4'd2, 1'b0, 4'd0, '0);
    checks++;
    if (lat != 1 || n_rd != 0 || rf_ren !== 1'b0 || valA !== '0 || valB !== '0) begin
      errors++;
      $display("FAIL icode13_noread: lat=%0d reads=%0d ren=%b valA=%0h valB=%0h expected 1/0/0/0/0",
               lat, n_rd, rf_ren, valA, valB);
    end
    finish_handshake("icode13");
  endtask

  task automatic test_reset_mid_op();
    regs[5] = 64'h55;
    regs[6] = 64'h66;
    icode = 4'd4; rA = 4'd5; rB = 4'd6;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (rf_ren !== 1'b1 || rf_raddr !== 4'd5) begin
      errors++;
      $display("FAIL rmmovq_rd_a: ren=%b raddr=%0d expected 1/5", rf_ren, rf_raddr);
    end
    @(posedge clk); #1;
    checks++;
    if (rf_ren !== 1'b1 || rf_raddr !== 4'd6) begin
      errors++;
      $display("FAIL rmmovq_rd_b: ren=%b raddr=%0d expected 1/6", rf_ren, rf_raddr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || out_valid !== 1'b0 || rf_ren !== 1'b0 ||
        rf_raddr !== 4'd15 || valA !== '0 || valB !== '0) begin
      errors++;
      $display("FAIL midop_reset: rdy=%b ov=%b ren=%b raddr=%0d valA=%0h valB=%0h expected 1/0/0/15/0/0",
               req_ready, out_valid, rf_ren, rf_raddr, valA, valB);
    end
    $display("req icode=4 aborted by reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(4'd6, 4'd5, 4'd6, 1'b0, 4'd0, '0);
    checks++;
    if (lat != 3 || valA !== 64'h55 || valB !== 64'h66) begin
      errors++;
      $display("FAIL after_reset_req: lat=%0d valA=%0h valB=%0h expected 3/55/66", lat, valA, valB);
    end
    finish_handshake("after_reset");
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 64'(i) * 64'h100;
    req_valid = 1'b0;
    icode = '0; rA = '0; rB = '0;
    wb_en = 1'b0; wb_dst = '0; wb_data = '0;
    out_ready = 1'b1;
    test_reset();
    test_two_reads();
    test_popq_shared_read();
    test_forward_in_read();
    test_done_freshen();
    test_no_reads();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
